// File: rtl/blink_meter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : blink_meter
// Brief    : Measures period and high time of an async square wave in clk
//            cycles, strobes each result and flags loss of signal.
//            Optional period-tolerance check: define BLINK_METER_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
module blink_meter #(
  parameter int unsigned C_CLK_FRQ    = 100000000,
  parameter int unsigned C_TIMEOUT    = 50,
  parameter int unsigned C_CNT_W      = 32,
  parameter int unsigned C_EXP_PERIOD = 10,
  parameter int unsigned C_TOL        = 100
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               in,
  output logic [C_CNT_W-1:0] period,
  output logic [C_CNT_W-1:0] high,
  output logic               valid,
  output logic               timeout,
  output logic               match
);

  localparam logic [63:0] C_TO_CYC = 64'(C_CLK_FRQ / 1000) * 64'(C_TIMEOUT);
  localparam logic [C_CNT_W-1:0] C_TO_LAST = C_CNT_W'(C_TO_CYC - 64'd1);

  if ((C_TO_CYC >> C_CNT_W) != 64'd0) begin : g_to_range_err
    $error("blink_meter: timeout cycle count does not fit in C_CNT_W bits");
  end

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_s1, r_s2, r_s3;
  logic [1:0]         r_fill;
  logic [C_CNT_W-1:0] r_cnt;
  logic [C_CNT_W-1:0] r_high_sh;
  logic [C_CNT_W-1:0] w_cnt_inc;
  logic               w_armed, w_rise, w_fall, w_to_hit, w_publish;

  // Edges are ignored until s3 holds a real sample, so a line already high
  // at reset release is not mistaken for a rising edge.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_fill <= 2'd0;
    end else begin
      r_s1 <= in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
    end
  end

  assign w_armed   = (r_fill == 2'd3);
  assign w_rise    = w_armed & r_s2 & ~r_s3;
  assign w_fall    = w_armed & ~r_s2 & r_s3;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_publish = (r_state == ST_MEASURE) && w_rise;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_to_hit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) w_state_nxt = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (!w_rise && (r_cnt == C_TO_LAST)) begin
          w_to_hit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_cnt     <= '0;
      r_high_sh <= '0;
      period    <= '0;
      high      <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= w_publish;
      if ((r_state == ST_MEASURE) && !w_rise && !w_to_hit) r_cnt <= w_cnt_inc;
      else                                                 r_cnt <= '0;
      if ((r_state == ST_MEASURE) && w_fall) r_high_sh <= w_cnt_inc;
      if (w_publish) begin
        period  <= w_cnt_inc;
        high    <= r_high_sh;
        timeout <= 1'b0;
      end else if (w_to_hit) begin
        timeout <= 1'b1;
      end
    end
  end

`ifdef BLINK_METER_CHECK_EN
  localparam logic [C_CNT_W-1:0] C_EXP_CYC = C_CNT_W'(64'(C_CLK_FRQ / 1000) * 64'(C_EXP_PERIOD));
  localparam logic [C_CNT_W-1:0] C_TOL_W   = C_CNT_W'(C_TOL);

  logic [C_CNT_W-1:0] w_dev;
  logic               w_in_tol;

  assign w_dev    = (w_cnt_inc >= C_EXP_CYC) ? (w_cnt_inc - C_EXP_CYC) : (C_EXP_CYC - w_cnt_inc);
  assign w_in_tol = (w_dev <= C_TOL_W);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)          match <= 1'b0;
    else if (w_publish) match <= w_in_tol;
    else if (w_to_hit)  match <= 1'b0;
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{C_EXP_PERIOD, C_TOL};
  assign match        = 1'b0;
`endif

endmodule
`default_nettype wire
